csadd_pipe: RTL and testbench
=============================

Name: csadd_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 32-bit combinational carry-select adder.
- Splits WIDTH into STAGES segments. Each segment is resolved by a carry-select pair, one segment per pipeline stage.
- Valid/ready streaming handshake with backpressure, one result per cycle.
- Sits between operand-issue logic and the result bus of the lab datapath.

Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of STAGES.
- STAGES, 4, pipeline stages = segment count; SEG = WIDTH/STAGES bits per stage (derived localparam); 1 <= STAGES <= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand transaction offered
- in_ready  out  1  block can accept this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  0 = A+B+cin, 1 = A-B (cin ignored)
- in_cin  in  1  carry-in for add
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry-out; for subtract, 1 = no borrow
- out_ovf  out  1  two's-complement signed overflow

Behaviour:
- Reset (async assert, sync release): all stage valid bits 0; out_valid=0; out_sum=0, out_cout=0, out_ovf=0. In-flight transactions are discarded, including on reset mid-operation.
- Subtract: B operand = ~in_b, carry-in = 1. Add: B operand = in_b, carry-in = in_cin.
- Stage k (k=0..STAGES-1) adds segment k as a carry-select pair: SEG-bit sums for carry 0 and carry 1, muxed by the carry registered from stage k-1. Stage 0 muxes by the input carry.
- Stage k registers: completed low sum bits, carry, untouched high operand bits, and the sign bits needed for overflow.
- Latency: a transaction accepted on edge n is in the output register after edge n+STAGES-1. STAGES=1 gives a registered single-cycle adder.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - Accept when in_valid & in_ready.
  - On stall every stage holds contents, including bubbles; bubbles do not collapse.
  - Without stall, each stage advances every cycle. A stage valid is loaded from the previous stage valid; stage 0 valid loads in_valid & in_ready.
- Throughput: one result per cycle while out_ready=1.
- out_* are stable while out_valid & ~out_ready.
- out_valid drops after a handshake if the previous stage held a bubble.
- Overflow: out_ovf = carry into MSB XOR carry out of MSB.
- Wrap-around: sums are modulo 2^WIDTH; carry is reported only on out_cout.
- Simultaneous accept and output handshake in one cycle: both occur, no loss.

Optional Feature:
- Macro CSADD_PIPE_SAT_EN.
- Defined: when overflow occurs, out_sum saturates to the signed limit: 0x7F..F if the operand sign (A, effective B) is 0, 0x80..0 if 1. out_ovf still reports 1; out_cout is unchanged.
- Undefined: out_sum is the wrapped result; no saturation logic is present.

Decomposition:
- Package csadd_pkg: localparams OP_ADD=1'b0, OP_SUB=1'b1; a function computing SEG; a stage-register struct typedef (valid, sum_lo, carry, a_hi, b_hi, sign bits).
- One sub-module, csel_seg: combinational SEG-bit carry-select segment. Inputs a, b, cin; outputs sum, cout, and carry-into-MSB for overflow. Instantiated STAGES times in a generate loop.

Test Plan:
- WIDTH=32, STAGES=4, add 0xFFFFFFFF + 0x00000001, cin=0 -> out_sum=0x00000000, cout=1, ovf=0; out_valid after 4th edge counting the acceptance edge.
- sub 0x00000005 - 0x00000007 -> out_sum=0xFFFFFFFE, cout=0 (borrow), ovf=0.
- add 0x7FFFFFFF + 0x00000001 -> out_sum=0x80000000, ovf=1. With CSADD_PIPE_SAT_EN: out_sum=0x7FFFFFFF, ovf=1.
- 8 back-to-back adds i + 0x10 (i=0..7), out_ready=1 -> results 0x10..0x17 in order on consecutive cycles, in_ready stays 1.
- Hold out_ready=0 for 5 cycles with the pipe full -> in_ready=0, out_sum constant. Release -> no loss or duplication; 8 results in order.
- Assert rst_n=0 mid-stream for 1 cycle -> out_valid=0 and outputs 0 immediately. After release, the next accepted 3+4 yields 7 with no stale results emitted.

Source files
------------

// File: rtl/csadd_pkg.sv
// Shared definitions for the pipelined carry-select adder/subtractor.
// Operation codes, segment-width helper and the per-stage control record.
package csadd_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int csadd_seg_w(input int width, input int stages);
        return width / stages;
    endfunction

    typedef struct packed {
        logic vld;
        logic carry;
    } csadd_ctl_t;

endpackage

// File: rtl/csel_seg.sv
// Combinational carry-select segment: both carry hypotheses are summed in
// parallel and the incoming carry picks one.
module csel_seg #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [SEG_W:0] sum_c0;
    logic [SEG_W:0] sum_c1;

    assign sum_c0 = {1'b0, a} + {1'b0, b};
    assign sum_c1 = {1'b0, a} + {1'b0, b} + (SEG_W + 1)'(1);

    assign {cout, sum} = cin ? sum_c1 : sum_c0;

    // Carry into the top bit, recovered from the selected sum bit.
    assign cmsb = sum[SEG_W-1] ^ a[SEG_W-1] ^ b[SEG_W-1];

endmodule

// File: rtl/csadd_pipe.sv
// Pipelined carry-select adder/subtractor, one SEG-bit segment per stage,
// valid/ready streaming with full-pipe stall. Optional CSADD_PIPE_SAT_EN saturates on overflow.
module csadd_pipe
    import csadd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SEG  = csadd_seg_w(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    csadd_ctl_t       ctl_p    [STAGES];
    logic [WIDTH-1:0] sum_p    [STAGES];
    logic [WIDTH-1:0] a_p      [STAGES];
    logic [WIDTH-1:0] b_p      [STAGES];
    logic             ovf_p;

    logic [WIDTH-1:0] a_src    [STAGES];
    logic [WIDTH-1:0] b_src    [STAGES];
    logic [WIDTH-1:0] sum_src  [STAGES];
    logic [WIDTH-1:0] sum_nxt  [STAGES];
    logic             cin_src  [STAGES];
    logic             vld_src  [STAGES];
    logic [SEG-1:0]   seg_sum  [STAGES];
    logic             seg_cout [STAGES];
    logic             seg_cmsb [STAGES];

    logic             stall;
    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             ovf_nxt;
    logic [WIDTH-1:0] out_nxt;

`ifdef CSADD_PIPE_SAT_EN
    // Positive overflow clamps to the max, negative to the min.
    function automatic logic [WIDTH-1:0] sat_limit(input logic sign);
        return {sign, {(WIDTH-1){~sign}}};
    endfunction
`endif

    assign stall    = ctl_p[LAST].vld & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = advance;

    assign b_eff   = (in_sub == OP_SUB) ? ~in_b : in_b;
    assign cin_eff = (in_sub == OP_ADD) ? in_cin : 1'b1;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_src
            assign a_src[k]   = in_a;
            assign b_src[k]   = b_eff;
            assign sum_src[k] = '0;
            assign cin_src[k] = cin_eff;
            assign vld_src[k] = in_valid & in_ready;
        end else begin : g_src
            assign a_src[k]   = a_p[k-1];
            assign b_src[k]   = b_p[k-1];
            assign sum_src[k] = sum_p[k-1];
            assign cin_src[k] = ctl_p[k-1].carry;
            assign vld_src[k] = ctl_p[k-1].vld;
        end

        csel_seg #(
            .SEG_W (SEG)
        ) u_seg (
            .a    (a_src[k][SEG-1:0]),
            .b    (b_src[k][SEG-1:0]),
            .cin  (cin_src[k]),
            .sum  (seg_sum[k]),
            .cout (seg_cout[k]),
            .cmsb (seg_cmsb[k])
        );

        // Finished segments enter at the top and shift down, so after the
        // last stage the sum sits fully aligned.
        assign sum_nxt[k] = (sum_src[k] >> SEG) | (WIDTH'(seg_sum[k]) << (WIDTH - SEG));
    end

    assign ovf_nxt = seg_cmsb[LAST] ^ seg_cout[LAST];

`ifdef CSADD_PIPE_SAT_EN
    assign out_nxt = ovf_nxt ? sat_limit(a_src[LAST][SEG-1]) : sum_nxt[LAST];
`else
    assign out_nxt = sum_nxt[LAST];
`endif

    // ---- stage registers p0..p(STAGES-1); the last one is the output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_p[k] <= '0;
                sum_p[k] <= '0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
            end
            ovf_p <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_p[k].vld   <= vld_src[k];
                ctl_p[k].carry <= seg_cout[k];
                sum_p[k]       <= (k == LAST) ? out_nxt : sum_nxt[k];
                a_p[k]         <= a_src[k] >> SEG;
                b_p[k]         <= b_src[k] >> SEG;
            end
            ovf_p <= ovf_nxt;
        end
    end

    assign out_valid = ctl_p[LAST].vld;
    assign out_sum   = sum_p[LAST];
    assign out_cout  = ctl_p[LAST].carry;
    assign out_ovf   = ovf_p;

endmodule

// File: tb/tb_csadd_pipe.sv
// Self-checking bench for csadd_pipe: directed corner cases, streaming with
// backpressure, randomized traffic against an arithmetic model, and mid-stream reset.
`timescale 1ns/1ps
module tb_csadd_pipe;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    res_t exp_q[$];

    csadd_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Arithmetic reference using true integer values.
    function automatic res_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                    input logic sub, input logic cin);
        res_t r;
        longint unsigned uv;
        longint sa, sb, sv;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            uv = {32'd0, a} + 64'h1_0000_0000 - {32'd0, b};
            sv = sa - sb;
        end else begin
            uv = {32'd0, a} + {32'd0, b} + {63'd0, cin};
            sv = sa + sb + longint'(cin);
        end
        r.sum  = uv[31:0];
        r.cout = uv[32];
        r.ovf  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
`ifdef CSADD_PIPE_SAT_EN
        if (r.ovf) r.sum = (sv > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return r;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_cin   = cin;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b s=%h c=%b o=%b, required all zero",
                     out_valid, out_sum, out_cout, out_ovf);
        end
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: out_valid %b, required 0", out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [6];
        logic [31:0] tb [6];
        logic        tsub [6];
        logic        tcin [6];
        logic [31:0] es [6];
        logic        ec [6];
        logic        eo [6];
        int edges;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0001; tsub[0] = 0; tcin[0] = 0;
        es[0] = 32'h0000_0000; ec[0] = 1; eo[0] = 0;
        ta[1] = 32'h0000_0005; tb[1] = 32'h0000_0007; tsub[1] = 1; tcin[1] = 0;
        es[1] = 32'hFFFF_FFFE; ec[1] = 0; eo[1] = 0;
        ta[2] = 32'h7FFF_FFFF; tb[2] = 32'h0000_0001; tsub[2] = 0; tcin[2] = 0;
        es[2] = 32'h8000_0000; ec[2] = 0; eo[2] = 1;
        ta[3] = 32'h8000_0000; tb[3] = 32'h0000_0001; tsub[3] = 1; tcin[3] = 1;
        es[3] = 32'h7FFF_FFFF; ec[3] = 1; eo[3] = 1;
        ta[4] = 32'h0000_FFFF; tb[4] = 32'h0000_FFFF; tsub[4] = 0; tcin[4] = 1;
        es[4] = 32'h0001_FFFF; ec[4] = 0; eo[4] = 0;
        ta[5] = 32'h0000_0007; tb[5] = 32'h0000_0007; tsub[5] = 1; tcin[5] = 0;
        es[5] = 32'h0000_0000; ec[5] = 1; eo[5] = 0;
`ifdef CSADD_PIPE_SAT_EN
        es[2] = 32'h7FFF_FFFF;
        es[3] = 32'h8000_0000;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_in(1'b1, ta[i], tb[i], tsub[i], tcin[i]);
            @(posedge clk);
            edges = 1;
            @(negedge clk);
            set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            while (!out_valid && edges < 20) begin
                @(posedge clk);
                edges++;
                @(negedge clk);
            end
            n_tests++;
            if (edges !== STAGES || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: valid after %0d edges (v=%b), required %0d",
                         i, edges, out_valid, STAGES);
            end
            n_tests++;
            if (out_sum !== es[i] || out_cout !== ec[i] || out_ovf !== eo[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got s=%h c=%b o=%b, required s=%h c=%b o=%b",
                         i, out_sum, out_cout, out_ovf, es[i], ec[i], eo[i]);
            end
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_drop[%0d]: out_valid %b after handshake, required 0",
                         i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int got = 0;
        int first = -1;
        int last = -1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 8 + STAGES + 4; cyc++) begin
            @(negedge clk);
            if (issued < 8) set_in(1'b1, issued, 32'h10, 1'b0, 1'b0);
            else set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            #1;
            if (issued < 8) begin
                n_tests++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_in_ready: cycle %0d in_ready %b, required 1", cyc, in_ready);
                end
            end
            if (out_valid) begin
                n_tests++;
                if (out_sum !== 32'h10 + got || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got s=%h c=%b o=%b, required s=%h c=0 o=0",
                             got, out_sum, out_cout, out_ovf, 32'h10 + got);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (in_valid && in_ready) issued++;
        end
        n_tests++;
        if (got !== 8 || last - first !== 7) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results spanning %0d cycles, required 8 spanning 7",
                     got, last - first);
        end
    endtask

    task automatic test_stall();
        int issued = 0;
        int got = 0;
        int cyc = 0;
        logic [31:0] held = '0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = (cyc >= STAGES + 5);
            if (issued < 8) set_in(1'b1, 32'h100 + issued, 32'h1, 1'b0, 1'b0);
            else set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            #1;
            if (cyc == STAGES) held = out_sum;
            if (cyc >= STAGES && cyc < STAGES + 5) begin
                n_tests++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== held) begin
                    n_fail++;
                    $display("FAIL stall_hold: cycle %0d in_ready=%b v=%b s=%h, required 0/1/%h",
                             cyc, in_ready, out_valid, out_sum, held);
                end
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (out_sum !== 32'h101 + got) begin
                    n_fail++;
                    $display("FAIL stall_result[%0d]: got %h, required %h", got, out_sum, 32'h101 + got);
                end
                got++;
            end
            if (in_valid && in_ready) issued++;
            cyc++;
        end
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        n_tests++;
        if (got !== 8) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results, required 8", got);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_dup: out_valid %b after last result, required 0", out_valid);
        end
    endtask

    task automatic test_random();
        res_t r;
        logic prev_stall = 1'b0;
        logic [31:0] prev_sum = '0;
        logic prev_c = 1'b0;
        logic prev_o = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_sum !== prev_sum || out_cout !== prev_c || out_ovf !== prev_o) begin
                    n_fail++;
                    $display("FAIL rand_stable: cycle %0d v=%b s=%h c=%b o=%b, required 1 %h %b %b",
                             cyc, out_valid, out_sum, out_cout, out_ovf, prev_sum, prev_c, prev_o);
                end
            end
            if (cyc < 400) begin
                out_ready = ($urandom_range(0, 3) != 0);
                set_in($urandom_range(0, 3) != 0, rand_operand(), rand_operand(),
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end else begin
                out_ready = 1'b1;
                set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            end
            #1;
            n_tests++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_fail++;
                $display("FAIL rand_in_ready: cycle %0d in_ready=%b v=%b r=%b", cyc, in_ready, out_valid, out_ready);
            end
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_unexpected: result %h with nothing outstanding", out_sum);
                end else begin
                    r = exp_q.pop_front();
                    if (out_sum !== r.sum || out_cout !== r.cout || out_ovf !== r.ovf) begin
                        n_fail++;
                        $display("FAIL rand_result: got s=%h c=%b o=%b, required s=%h c=%b o=%b",
                                 out_sum, out_cout, out_ovf, r.sum, r.cout, r.ovf);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_op(in_a, in_b, in_sub, in_cin));
            prev_stall = out_valid && !out_ready;
            prev_sum   = out_sum;
            prev_c     = out_cout;
            prev_o     = out_ovf;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        int edges;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_in(1'b1, 32'h1000 + i, 32'h1, 1'b0, 1'b0);
        end
        @(negedge clk);
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got v=%b s=%h c=%b o=%b, required all zero",
                     out_valid, out_sum, out_cout, out_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_in(1'b1, 32'd3, 32'd4, 1'b0, 1'b0);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        n_tests++;
        if (edges !== STAGES || out_sum !== 32'd7 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_first: after %0d edges s=%h c=%b o=%b, required %0d edges s=7 c=0 o=0",
                     edges, out_sum, out_cout, out_ovf, STAGES);
        end
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stale: out_valid %b after sole result, required 0", out_valid);
        end
    endtask

    initial begin
        out_ready = 1'b1;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
